// File: rtl/fe_decode_stage.sv
// fe_decode_stage: front-end decode stage between the fetch queue and the issue logic.
// One 16-bit Thumb-style instruction per cycle is accepted over valid/ready. Its
// microcode word is looked up combinationally on instr[15:6]. The word is registered
// together with the raw instruction, PC, sequence tag and illegal flag, and then
// presented downstream over valid/ready.
//
// Handshake rules, on both sides: a beat transfers on a rising edge where valid and
// ready are both high. While valid is high and ready is low, the sender holds valid
// and every payload field stable.
//
// Build option FE_DECODE_SKID_EN:
//   defined   -> 2-entry main+skid buffer; fetch_ready_o is purely registered.
//   undefined -> single output register; fetch_ready_o looks through issue_ready_i.

package fe_decode_pkg;

    localparam int UCODE_WIDTH_P = 16;

    // Microcode word layout: {unit[3:0], func[3:0], imm_sel[2:0], wr_rd, set_flags,
    // mem_rd, mem_wr, branch}. Every legal row has a non-zero unit, so an all-zero
    // word can only mean "no match".
    localparam logic [3:0] UNIT_ALU = 4'h1;
    localparam logic [3:0] UNIT_LSU = 4'h2;
    localparam logic [3:0] UNIT_BRU = 4'h3;

    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_SUB = 4'h1;
    localparam logic [3:0] FN_LSL = 4'h2;
    localparam logic [3:0] FN_LSR = 4'h3;
    localparam logic [3:0] FN_ASR = 4'h4;
    localparam logic [3:0] FN_MOV = 4'h5;
    localparam logic [3:0] FN_AND = 4'h6;
    localparam logic [3:0] FN_EOR = 4'h7;
    localparam logic [3:0] FN_ORR = 4'h8;
    localparam logic [3:0] FN_MVN = 4'h9;
    localparam logic [3:0] FN_BAL = 4'h0;
    localparam logic [3:0] FN_BCC = 4'h1;

    localparam logic [2:0] IMM_NONE  = 3'd0;
    localparam logic [2:0] IMM_5     = 3'd1;
    localparam logic [2:0] IMM_3     = 3'd2;
    localparam logic [2:0] IMM_8     = 3'd3;
    localparam logic [2:0] IMM_SP7   = 3'd4;
    localparam logic [2:0] IMM_OFF8  = 3'd5;
    localparam logic [2:0] IMM_OFF11 = 3'd6;
    localparam logic [2:0] IMM_PC8   = 3'd7;

    // Flag groups: {wr_rd, set_flags, mem_rd, mem_wr, branch}
    localparam logic [4:0] FL_NONE     = 5'b00000;
    localparam logic [4:0] FL_WR_FLAGS = 5'b11000;
    localparam logic [4:0] FL_FLAGS    = 5'b01000;
    localparam logic [4:0] FL_LOAD     = 5'b10100;
    localparam logic [4:0] FL_STORE    = 5'b00010;
    localparam logic [4:0] FL_BRANCH   = 5'b00001;

    localparam logic [UCODE_WIDTH_P-1:0] UC_LSL_IMM  = {UNIT_ALU, FN_LSL, IMM_5,     FL_WR_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_LSR_IMM  = {UNIT_ALU, FN_LSR, IMM_5,     FL_WR_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_ASR_IMM  = {UNIT_ALU, FN_ASR, IMM_5,     FL_WR_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_ADD_REG  = {UNIT_ALU, FN_ADD, IMM_NONE,  FL_WR_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_SUB_REG  = {UNIT_ALU, FN_SUB, IMM_NONE,  FL_WR_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_ADD_IMM3 = {UNIT_ALU, FN_ADD, IMM_3,     FL_WR_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_SUB_IMM3 = {UNIT_ALU, FN_SUB, IMM_3,     FL_WR_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_MOV_IMM  = {UNIT_ALU, FN_MOV, IMM_8,     FL_WR_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_CMP_IMM  = {UNIT_ALU, FN_SUB, IMM_8,     FL_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_ADD_IMM8 = {UNIT_ALU, FN_ADD, IMM_8,     FL_WR_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_SUB_IMM8 = {UNIT_ALU, FN_SUB, IMM_8,     FL_WR_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_AND      = {UNIT_ALU, FN_AND, IMM_NONE,  FL_WR_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_EOR      = {UNIT_ALU, FN_EOR, IMM_NONE,  FL_WR_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_ORR      = {UNIT_ALU, FN_ORR, IMM_NONE,  FL_WR_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_CMP_REG  = {UNIT_ALU, FN_SUB, IMM_NONE,  FL_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_MVN      = {UNIT_ALU, FN_MVN, IMM_NONE,  FL_WR_FLAGS};
    localparam logic [UCODE_WIDTH_P-1:0] UC_LDR_LIT  = {UNIT_LSU, FN_ADD, IMM_PC8,   FL_LOAD};
    localparam logic [UCODE_WIDTH_P-1:0] UC_STR_REG  = {UNIT_LSU, FN_ADD, IMM_NONE,  FL_STORE};
    localparam logic [UCODE_WIDTH_P-1:0] UC_LDR_REG  = {UNIT_LSU, FN_ADD, IMM_NONE,  FL_LOAD};
    localparam logic [UCODE_WIDTH_P-1:0] UC_STR_IMM  = {UNIT_LSU, FN_ADD, IMM_5,     FL_STORE};
    localparam logic [UCODE_WIDTH_P-1:0] UC_LDR_IMM  = {UNIT_LSU, FN_ADD, IMM_5,     FL_LOAD};
    localparam logic [UCODE_WIDTH_P-1:0] UC_ADD_SP   = {UNIT_ALU, FN_ADD, IMM_SP7,   FL_NONE};
    localparam logic [UCODE_WIDTH_P-1:0] UC_SUB_SP   = {UNIT_ALU, FN_SUB, IMM_SP7,   FL_NONE};
    localparam logic [UCODE_WIDTH_P-1:0] UC_BCOND    = {UNIT_BRU, FN_BCC, IMM_OFF8,  FL_BRANCH};
    localparam logic [UCODE_WIDTH_P-1:0] UC_B        = {UNIT_BRU, FN_BAL, IMM_OFF11, FL_BRANCH};

endpackage

module fe_decode_stage
    import fe_decode_pkg::*;
#(
    parameter int PC_WIDTH_P  = 16,
    parameter int SEQ_WIDTH_P = 6
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     fetch_v_i,
    input  logic [15:0]              fetch_instr_i,
    input  logic [PC_WIDTH_P-1:0]    fetch_pc_i,
    output logic                     fetch_ready_o,
    output logic                     issue_v_o,
    input  logic                     issue_ready_i,
    output logic [UCODE_WIDTH_P-1:0] issue_ucode_o,
    output logic [15:0]              issue_instr_o,
    output logic [PC_WIDTH_P-1:0]    issue_pc_o,
    output logic [SEQ_WIDTH_P-1:0]   issue_seq_o,
    output logic                     issue_illegal_o
);

    typedef struct packed {
        logic [UCODE_WIDTH_P-1:0] ucode;
        logic [15:0]              instr;
        logic [PC_WIDTH_P-1:0]    pc;
        logic [SEQ_WIDTH_P-1:0]   seq;
        logic                     illegal;
    } op_t;

    logic [9:0]               rom_addr;
    logic [UCODE_WIDTH_P-1:0] rom_word;
    op_t                      in_op;
    op_t                      main_q;
    logic                     main_v_q;
    logic [SEQ_WIDTH_P-1:0]   seq_q;
    logic                     accept;
    logic                     issue;

    assign rom_addr = fetch_instr_i[15:6];

    // Microcode ROM: patterns are non-overlapping; unlisted encodings (including
    // UDF/SVC and the 32-bit BL prefix space) fall to the all-zero default row.
    always_comb begin
        rom_word = '0;
        casez (rom_addr)
            10'b00000_?????: rom_word = UC_LSL_IMM;
            10'b00001_?????: rom_word = UC_LSR_IMM;
            10'b00010_?????: rom_word = UC_ASR_IMM;
            10'b0001100_???: rom_word = UC_ADD_REG;
            10'b0001101_???: rom_word = UC_SUB_REG;
            10'b0001110_???: rom_word = UC_ADD_IMM3;
            10'b0001111_???: rom_word = UC_SUB_IMM3;
            10'b00100_?????: rom_word = UC_MOV_IMM;
            10'b00101_?????: rom_word = UC_CMP_IMM;
            10'b00110_?????: rom_word = UC_ADD_IMM8;
            10'b00111_?????: rom_word = UC_SUB_IMM8;
            10'b0100000000:  rom_word = UC_AND;
            10'b0100000001:  rom_word = UC_EOR;
            10'b0100001100:  rom_word = UC_ORR;
            10'b0100001010:  rom_word = UC_CMP_REG;
            10'b0100001111:  rom_word = UC_MVN;
            10'b01001_?????: rom_word = UC_LDR_LIT;
            10'b0101000_???: rom_word = UC_STR_REG;
            10'b0101100_???: rom_word = UC_LDR_REG;
            10'b01100_?????: rom_word = UC_STR_IMM;
            10'b01101_?????: rom_word = UC_LDR_IMM;
            10'b101100000_?: rom_word = UC_ADD_SP;
            10'b101100001_?: rom_word = UC_SUB_SP;
            10'b1101_0?????: rom_word = UC_BCOND;
            10'b1101_10????: rom_word = UC_BCOND;
            10'b1101_110???: rom_word = UC_BCOND;
            10'b11100_?????: rom_word = UC_B;
            default:         rom_word = '0;
        endcase
    end

    // Bundle the incoming beat; the tag is the current sequence counter.
    always_comb begin
        in_op         = '0;
        in_op.ucode   = rom_word;
        in_op.instr   = fetch_instr_i;
        in_op.pc      = fetch_pc_i;
        in_op.seq     = seq_q;
        in_op.illegal = (rom_word == '0);
    end

    assign accept = fetch_v_i & fetch_ready_o & ~flush_i;
    assign issue  = main_v_q & issue_ready_i;

    // Sequence tag counter: advances once per accepted beat and wraps; flush leaves it alone.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            seq_q <= '0;
        end else if (accept) begin
            seq_q <= seq_q + 1'b1;
        end
    end

`ifdef FE_DECODE_SKID_EN
    op_t  skid_q;
    logic skid_v_q;

    // Ready depends only on the skid slot, so there is no path from issue_ready_i.
    assign fetch_ready_o = ~skid_v_q;

    // Main+skid buffer: the skid slot catches a beat arriving while main is stalled,
    // and refills main on the edge that main issues.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush_i) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else if (issue) begin
            if (skid_v_q) begin
                main_q   <= skid_q;
                skid_v_q <= 1'b0;
            end else if (accept) begin
                main_q <= in_op;
            end else begin
                main_v_q <= 1'b0;
            end
        end else if (accept) begin
            if (main_v_q) begin
                skid_q   <= in_op;
                skid_v_q <= 1'b1;
            end else begin
                main_q   <= in_op;
                main_v_q <= 1'b1;
            end
        end
    end
`else
    // A full register can still take a beat when it is being drained this cycle.
    assign fetch_ready_o = ~main_v_q | issue_ready_i;

    // Single output register: load on accept (replacing an issuing op), clear on a bare issue.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            main_v_q <= 1'b0;
            main_q   <= '0;
        end else if (flush_i) begin
            main_v_q <= 1'b0;
        end else if (accept) begin
            main_v_q <= 1'b1;
            main_q   <= in_op;
        end else if (issue) begin
            main_v_q <= 1'b0;
        end
    end
`endif

    assign issue_v_o       = main_v_q;
    assign issue_ucode_o   = main_q.ucode;
    assign issue_instr_o   = main_q.instr;
    assign issue_pc_o      = main_q.pc;
    assign issue_seq_o     = main_q.seq;
    assign issue_illegal_o = main_q.illegal;

endmodule

// File: tb/tb_fe_decode_stage.sv
// Bench for fe_decode_stage: table of ROM vectors, hand-written stall/flush/wrap/reset
// sequences, and a randomized phase checked every cycle against a queue-based model.

module tb_fe_decode_stage;
    import fe_decode_pkg::*;

    localparam int PCW  = 16;
    localparam int SEQW = 6;
    localparam int UW   = UCODE_WIDTH_P;
`ifdef FE_DECODE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic            clk = 1'b0;
    logic            reset_i = 1'b1;
    logic            flush_i = 1'b0;
    logic            fetch_v_i = 1'b0;
    logic [15:0]     fetch_instr_i = '0;
    logic [PCW-1:0]  fetch_pc_i = '0;
    logic            issue_ready_i = 1'b0;
    logic            fetch_ready_o;
    logic            issue_v_o;
    logic [UW-1:0]   issue_ucode_o;
    logic [15:0]     issue_instr_o;
    logic [PCW-1:0]  issue_pc_o;
    logic [SEQW-1:0] issue_seq_o;
    logic            issue_illegal_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fe_decode_stage #(.PC_WIDTH_P(PCW), .SEQ_WIDTH_P(SEQW)) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .fetch_v_i(fetch_v_i), .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
        .fetch_ready_o(fetch_ready_o), .issue_v_o(issue_v_o), .issue_ready_i(issue_ready_i),
        .issue_ucode_o(issue_ucode_o), .issue_instr_o(issue_instr_o), .issue_pc_o(issue_pc_o),
        .issue_seq_o(issue_seq_o), .issue_illegal_o(issue_illegal_o)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference ROM: first matching {mask, match} row ----------------
    typedef struct {
        logic [15:0]   mask;
        logic [15:0]   match;
        logic [UW-1:0] uc;
    } rom_row_t;
    rom_row_t rom_tbl[$];

    function automatic logic [UW-1:0] ref_ucode(input logic [15:0] ins);
        foreach (rom_tbl[i]) begin
            if ((ins & rom_tbl[i].mask) == rom_tbl[i].match) return rom_tbl[i].uc;
        end
        return '0;
    endfunction

    // ---------------- queue model of the stage ----------------
    typedef struct packed {
        logic [UW-1:0]   uc;
        logic [15:0]     instr;
        logic [PCW-1:0]  pc;
        logic [SEQW-1:0] seq;
        logic            ill;
    } op_t;
    op_t             mq[$];
    logic [SEQW-1:0] mseq = '0;
    bit              live = 1'b0;
    bit              zero_data = 1'b1;

    function automatic bit model_ready();
`ifdef FE_DECODE_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || issue_ready_i;
`endif
    endfunction

    always @(posedge clk) begin
        bit  acc;
        bit  iss;
        op_t o;
        if (reset_i) begin
            mq.delete();
            mseq = '0;
            zero_data = 1'b1;
            live = 1'b1;
        end else if (live) begin
            acc = fetch_v_i && model_ready() && !flush_i;
            iss = (mq.size() > 0) && issue_ready_i;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (iss) void'(mq.pop_front());
                if (acc) begin
                    o.uc    = ref_ucode(fetch_instr_i);
                    o.instr = fetch_instr_i;
                    o.pc    = fetch_pc_i;
                    o.seq   = mseq;
                    o.ill   = (o.uc == '0);
                    mq.push_back(o);
                    mseq = mseq + 1'b1;
                    zero_data = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("fetch_ready", fetch_ready_o, model_ready());
            chk("issue_v", issue_v_o, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("issue_ucode", issue_ucode_o, mq[0].uc);
                chk("issue_instr", issue_instr_o, mq[0].instr);
                chk("issue_pc", issue_pc_o, mq[0].pc);
                chk("issue_seq", issue_seq_o, mq[0].seq);
                chk("issue_illegal", issue_illegal_o, mq[0].ill);
            end else if (zero_data) begin
                chk("idle_ucode_zero", issue_ucode_o, 0);
                chk("idle_instr_zero", issue_instr_o, 0);
                chk("idle_pc_zero", issue_pc_o, 0);
                chk("idle_seq_zero", issue_seq_o, 0);
                chk("idle_illegal_zero", issue_illegal_o, 0);
            end
        end
    end

    // ---------------- ROM vector table ----------------
    typedef struct {
        logic [15:0]   instr;
        logic [UW-1:0] uc;
        logic          ill;
    } vec_t;
    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        flush_i = 1'b0;
        fetch_v_i = 1'b0;
        issue_ready_i = 1'b0;
        cyc();
        cyc();
        reset_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int          n_acc;
        int          b;
        int          issued;
        logic [15:0] burst[3];
        logic [SEQW-1:0] exp_q[$];

        rom_tbl.push_back('{16'hF800, 16'h0000, UC_LSL_IMM});
        rom_tbl.push_back('{16'hF800, 16'h0800, UC_LSR_IMM});
        rom_tbl.push_back('{16'hF800, 16'h1000, UC_ASR_IMM});
        rom_tbl.push_back('{16'hFE00, 16'h1800, UC_ADD_REG});
        rom_tbl.push_back('{16'hFE00, 16'h1A00, UC_SUB_REG});
        rom_tbl.push_back('{16'hFE00, 16'h1C00, UC_ADD_IMM3});
        rom_tbl.push_back('{16'hFE00, 16'h1E00, UC_SUB_IMM3});
        rom_tbl.push_back('{16'hF800, 16'h2000, UC_MOV_IMM});
        rom_tbl.push_back('{16'hF800, 16'h2800, UC_CMP_IMM});
        rom_tbl.push_back('{16'hF800, 16'h3000, UC_ADD_IMM8});
        rom_tbl.push_back('{16'hF800, 16'h3800, UC_SUB_IMM8});
        rom_tbl.push_back('{16'hFFC0, 16'h4000, UC_AND});
        rom_tbl.push_back('{16'hFFC0, 16'h4040, UC_EOR});
        rom_tbl.push_back('{16'hFFC0, 16'h4300, UC_ORR});
        rom_tbl.push_back('{16'hFFC0, 16'h4280, UC_CMP_REG});
        rom_tbl.push_back('{16'hFFC0, 16'h43C0, UC_MVN});
        rom_tbl.push_back('{16'hF800, 16'h4800, UC_LDR_LIT});
        rom_tbl.push_back('{16'hFE00, 16'h5000, UC_STR_REG});
        rom_tbl.push_back('{16'hFE00, 16'h5800, UC_LDR_REG});
        rom_tbl.push_back('{16'hF800, 16'h6000, UC_STR_IMM});
        rom_tbl.push_back('{16'hF800, 16'h6800, UC_LDR_IMM});
        rom_tbl.push_back('{16'hFF80, 16'hB000, UC_ADD_SP});
        rom_tbl.push_back('{16'hFF80, 16'hB080, UC_SUB_SP});
        rom_tbl.push_back('{16'hFF00, 16'hDE00, '0});
        rom_tbl.push_back('{16'hFF00, 16'hDF00, '0});
        rom_tbl.push_back('{16'hF000, 16'hD000, UC_BCOND});
        rom_tbl.push_back('{16'hF800, 16'hE000, UC_B});

        vecs[0]  = '{16'h1888, UC_ADD_REG,  1'b0};
        vecs[1]  = '{16'hFFFF, '0,          1'b1};
        vecs[2]  = '{16'h2005, UC_MOV_IMM,  1'b0};
        vecs[3]  = '{16'h0048, UC_LSL_IMM,  1'b0};
        vecs[4]  = '{16'h1E48, UC_SUB_IMM3, 1'b0};
        vecs[5]  = '{16'h4008, UC_AND,      1'b0};
        vecs[6]  = '{16'h4040, UC_EOR,      1'b0};
        vecs[7]  = '{16'h4080, '0,          1'b1};
        vecs[8]  = '{16'h6808, UC_LDR_IMM,  1'b0};
        vecs[9]  = '{16'h6008, UC_STR_IMM,  1'b0};
        vecs[10] = '{16'hD0FE, UC_BCOND,    1'b0};
        vecs[11] = '{16'hDE00, '0,          1'b1};
        vecs[12] = '{16'hE7FE, UC_B,        1'b0};
        vecs[13] = '{16'hB082, UC_SUB_SP,   1'b0};
        vecs[14] = '{16'hB002, UC_ADD_SP,   1'b0};
        vecs[15] = '{16'h4800, UC_LDR_LIT,  1'b0};
        vecs[16] = '{16'hDF05, '0,          1'b1};
        vecs[17] = '{16'h8000, '0,          1'b1};

        do_reset();

        // ADDS register form, first op after reset
        fetch_v_i = 1'b1; fetch_instr_i = 16'h1888; fetch_pc_i = 16'h0040; issue_ready_i = 1'b1;
        cyc();
        fetch_v_i = 1'b0;
        chk("t1_v", issue_v_o, 1);
        chk("t1_ucode", issue_ucode_o, UC_ADD_REG);
        chk("t1_instr", issue_instr_o, 16'h1888);
        chk("t1_pc", issue_pc_o, 16'h0040);
        chk("t1_seq", issue_seq_o, 0);
        chk("t1_illegal", issue_illegal_o, 0);

        // Unmatched encoding
        fetch_v_i = 1'b1; fetch_instr_i = 16'hFFFF; fetch_pc_i = 16'h0042;
        cyc();
        fetch_v_i = 1'b0;
        chk("t2_v", issue_v_o, 1);
        chk("t2_ucode", issue_ucode_o, 0);
        chk("t2_illegal", issue_illegal_o, 1);

        // ROM table, back to back
        for (int i = 0; i < NV; i++) begin
            fetch_v_i = 1'b1; fetch_instr_i = vecs[i].instr; fetch_pc_i = 16'(16'h0100 + 2 * i);
            cyc();
            chk($sformatf("vec%0d_ucode", i), issue_ucode_o, vecs[i].uc);
            chk($sformatf("vec%0d_illegal", i), issue_illegal_o, vecs[i].ill);
            chk($sformatf("vec%0d_instr", i), issue_instr_o, vecs[i].instr);
        end
        fetch_v_i = 1'b0;
        cyc();

        // Stall with three beats, then release; ops must leave in order 0,1,2
        do_reset();
        burst[0] = 16'h1888; burst[1] = 16'h2005; burst[2] = 16'hFFFF;
        exp_q = '{6'd0, 6'd1, 6'd2};
        n_acc = 0; b = 0; issued = 0;
        for (int c = 0; c < 12; c++) begin
            fetch_v_i = (b < 3);
            fetch_instr_i = (b < 3) ? burst[b] : 16'h0;
            fetch_pc_i = 16'(16'h0200 + 2 * b);
            issue_ready_i = (c >= 3);
            @(negedge clk);
            if (c < 3 && fetch_ready_o) n_acc++;
            if (c == 2) chk("stall_head_seq", issue_seq_o, 0);
            if (fetch_v_i && fetch_ready_o) b++;
            if (issue_v_o && issue_ready_i) begin
                issued++;
                if (exp_q.size() > 0) chk("release_seq", issue_seq_o, exp_q.pop_front());
            end
            @(posedge clk);
            #1;
        end
        chk("stall_accepts", n_acc, CAP);
        chk("release_count", issued, 3);
        fetch_v_i = 1'b0;

        // Flush with ops held and a fetch beat present
        do_reset();
        issue_ready_i = 1'b0;
        fetch_v_i = 1'b1; fetch_instr_i = 16'h3001; fetch_pc_i = 16'h0300;
        cyc();
        fetch_instr_i = 16'h3802; fetch_pc_i = 16'h0302;
        cyc();
        flush_i = 1'b1; fetch_instr_i = 16'h4008; fetch_pc_i = 16'h0304;
        cyc();
        flush_i = 1'b0; fetch_v_i = 1'b0;
        chk("flush_v", issue_v_o, 0);
        chk("flush_ready", fetch_ready_o, 1);
        cyc();
        chk("flush_no_accept", issue_v_o, 0);
        fetch_v_i = 1'b1; issue_ready_i = 1'b1; fetch_instr_i = 16'h1A00; fetch_pc_i = 16'h0306;
        cyc();
        fetch_v_i = 1'b0;
        chk("post_flush_v", issue_v_o, 1);
        chk("post_flush_seq", issue_seq_o, CAP);
        cyc();

        // 70 back-to-back beats: no bubbles, tag wraps 63 -> 0
        do_reset();
        issue_ready_i = 1'b1;
        for (int k = 0; k < 70; k++) begin
            fetch_v_i = 1'b1;
            fetch_instr_i = vecs[$urandom_range(NV - 1, 0)].instr;
            fetch_pc_i = 16'(2 * k);
            cyc();
            chk($sformatf("stream%0d_v", k), issue_v_o, 1);
            chk($sformatf("stream%0d_seq", k), issue_seq_o, k % 64);
        end
        fetch_v_i = 1'b0;
        cyc();

        // Reset while ops are held
        issue_ready_i = 1'b0;
        fetch_v_i = 1'b1; fetch_instr_i = 16'h2811; fetch_pc_i = 16'h0400;
        cyc();
        fetch_instr_i = 16'h6808; fetch_pc_i = 16'h0402;
        cyc();
        reset_i = 1'b1; fetch_v_i = 1'b0;
        cyc();
        reset_i = 1'b0;
        chk("rst_v", issue_v_o, 0);
        chk("rst_ucode", issue_ucode_o, 0);
        chk("rst_instr", issue_instr_o, 0);
        chk("rst_pc", issue_pc_o, 0);
        chk("rst_seq", issue_seq_o, 0);
        chk("rst_illegal", issue_illegal_o, 0);
        chk("rst_ready", fetch_ready_o, 1);
        fetch_v_i = 1'b1; issue_ready_i = 1'b1; fetch_instr_i = 16'hE7FE; fetch_pc_i = 16'h0500;
        cyc();
        fetch_v_i = 1'b0;
        chk("rst_next_v", issue_v_o, 1);
        chk("rst_next_seq", issue_seq_o, 0);

        // Randomized traffic against the model
        for (int r = 0; r < 500; r++) begin
            reset_i = ($urandom_range(119, 0) == 0);
            flush_i = ($urandom_range(24, 0) == 0);
            fetch_v_i = ($urandom_range(3, 0) != 0);
            fetch_instr_i = ($urandom_range(1, 0) != 0) ? vecs[$urandom_range(NV - 1, 0)].instr
                                                        : 16'($urandom);
            fetch_pc_i = 16'($urandom);
            issue_ready_i = ($urandom_range(9, 0) < 7);
            cyc();
        end
        reset_i = 1'b0; flush_i = 1'b0; fetch_v_i = 1'b0; issue_ready_i = 1'b1;
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
